masked_stage2_random_source: RTL and testbench
==============================================

// Module: masked_stage2_random_source
// PURPOSE
// - Producer end of the fresh-randomness interface of the second masked GF(2^8) inverse stage (HPC3 variant).
// - Expands a 128-bit seed with an xorshift128 generator.
// - Drives NUM_RANDOM bits per cycle into the stage's random input.
// - Seeding is a valid/ready word handshake. A warm-up phase runs before output is declared valid.
// PARAMETERS
// NUM_SHARES     2                                 share count of the consuming stage
// NUM_RANDOM     stage_2_hpc3_randoms(NUM_SHARES)  output bits per cycle; legal range 1..128 (14 for 2 shares)
// WARMUP_CYCLES  16                                generator steps discarded after seeding; 0 allowed
// PORTS
// in_clock          in   1           single clock, rising edge
// in_reset          in   1           asynchronous, active-high reset
// in_seed           in   32          seed word
// in_seed_valid     in   1           seed word offered this cycle
// out_seed_ready    out  1           seed word accepted when valid && ready
// in_advance        in   1           consumer used out_random this cycle; step generator
// out_random        out  NUM_RANDOM  fresh randomness = state[NUM_RANDOM-1:0], zero while not valid
// out_random_valid  out  1           out_random is usable
// BEHAVIOUR
// - State: four 32-bit words x, y, z, w. state = {w, z, y, x}.
//   - 2-bit word counter and warm-up counter.
//   - FSM states: UNSEEDED, LOAD, WARMUP, RUN.
// - Reset (async, any state, mid-operation included):
//   - FSM = UNSEEDED, all words 0, counters 0.
//   - out_random = 0, out_random_valid = 0, out_seed_ready = 1.
// - Step function:
//   - t = x ^ (x << 11)
//   - x <= y; y <= z; z <= w
//   - w <= w ^ (w >> 19) ^ t ^ (t >> 8)
//   - All shifts are logical, 32-bit.
// - Word accept (valid && ready):
//   - x <= y; y <= z; z <= w; w <= in_seed.
//   - The first of four words therefore ends in x.
// - out_seed_ready = 1 in UNSEEDED, LOAD and RUN; 0 in WARMUP (seed words offered then are ignored).
// - UNSEEDED: on accept -> LOAD, counter = 1.
// - LOAD: each accept increments the counter. On the 4th accept:
//   - Zero guard: if the resulting state is all zero, x is forced to 32'h1.
//   - Next state is WARMUP with counter = WARMUP_CYCLES, or RUN directly if WARMUP_CYCLES == 0.
// - WARMUP:
//   - One step per cycle, independent of in_advance.
//   - Counter decrements; at 1 -> RUN on that edge.
// - RUN:
//   - out_random_valid = 1, out_random = state[NUM_RANDOM-1:0], straight from registers (no combinational path from inputs).
//   - in_advance = 1 steps the generator: new value visible the next cycle.
//   - in_advance = 0 holds the state.
// - Reseed in RUN:
//   - An accepted word moves the FSM to LOAD with counter = 1. Valid drops the next cycle.
//   - Seed has priority over in_advance in the same cycle; no step occurs.
// - in_advance is ignored outside RUN.
// - Latency: valid rises 4 + WARMUP_CYCLES cycles after the first accepted seed word, assuming back-to-back words.
// TESTING
// - WARMUP_CYCLES=0, seeds 1,2,3,4 back-to-back:
//   - Valid rises the cycle after the 4th accept; out_random = 14'h0001.
//   - in_advance=1 for one cycle -> out_random = 14'h0002.
// - Same seed, NUM_RANDOM=128, one advance:
//   - Before: out_random = {32'h4, 32'h3, 32'h2, 32'h1}.
//   - After: out_random = {32'h80D, 32'h4, 32'h3, 32'h2}.
// - Four zero seed words, WARMUP_CYCLES=0 -> first out_random = 14'h0001 (zero guard).
// - WARMUP_CYCLES=16:
//   - Valid stays 0 for exactly 16 cycles after the 4th accept.
//   - Seed words offered during warm-up see ready = 0 and change nothing.
// - Reseed in RUN with in_advance=1 in the same cycle:
//   - Valid = 0 the next cycle; no step taken.
//   - After words 1,2,3,4 the output again equals the first-test values.
// - Assert in_reset after 2 seed words:
//   - Immediately valid = 0, out_random = 0, ready = 1.
//   - A full 4-word reload is required before valid rises.

Source files
------------

// File: rtl/masked_stage2_random_source_if.sv
// Fresh-randomness port bundle between the xorshift128 source (master) and its
// seeding/consuming side (slave).
interface masked_stage2_random_source_if #(
    parameter int NUM_RANDOM = 14
);
    // Handshake: a seed word transfers on a rising clock edge where in_seed_valid
    // and out_seed_ready are both 1. The seeder may hold or drop a word freely.
    // out_random is consumed when out_random_valid and in_advance are both 1.
    logic [31:0]           in_seed;
    logic                  in_seed_valid;
    logic                  out_seed_ready;
    logic                  in_advance;
    logic [NUM_RANDOM-1:0] out_random;
    logic                  out_random_valid;

    modport master (
        input  in_seed, in_seed_valid, in_advance,
        output out_seed_ready, out_random, out_random_valid
    );

    modport slave (
        output in_seed, in_seed_valid, in_advance,
        input  out_seed_ready, out_random, out_random_valid
    );
endinterface

// File: rtl/masked_stage2_random_source.sv
// xorshift128 randomness source feeding the second masked GF(2^8) inverse stage
// (HPC3). Seeded by four 32-bit words, then optionally warmed up before use.
module masked_stage2_random_source #(
    parameter int NUM_SHARES    = 2,
    // 14 fresh bits per share pair; 14 for two shares.
    parameter int NUM_RANDOM    = 14 * ((NUM_SHARES * (NUM_SHARES - 1)) / 2),
    parameter int WARMUP_CYCLES = 16
) (
    input  logic                                in_clock,
    input  logic                                in_reset,
    masked_stage2_random_source_if.master       rnd,
    output logic [1:0]                          out_fsm_state
);

    localparam int WCW = (WARMUP_CYCLES < 1) ? 1 : $clog2(WARMUP_CYCLES + 1);

    typedef enum logic [1:0] {
        S_UNSEEDED = 2'd0,
        S_LOAD     = 2'd1,
        S_WARMUP   = 2'd2,
        S_RUN      = 2'd3
    } fsm_e;

    fsm_e           fsm_q;
    logic [1:0]     word_cnt_q;
    logic [WCW-1:0] warm_cnt_q;
    logic           ready_q;
    logic           valid_q;

    logic [31:0] x_q, y_q, z_q, w_q;
    logic [31:0] x_d, y_d, z_d, w_d;
    logic [31:0] t_mix;
    logic [31:0] w_step;
    logic        accept;
    logic        do_step;
    logic        last_word;
    logic        load_zero;

    assign accept    = rnd.in_seed_valid && ready_q;
    assign last_word = (fsm_q == S_LOAD) && (word_cnt_q == 2'd3);
    assign load_zero = ({rnd.in_seed, w_q, z_q, y_q} == 128'd0);
    // Seed acceptance in RUN wins over in_advance: the shift-in replaces the step.
    assign do_step   = (fsm_q == S_WARMUP) ||
                       ((fsm_q == S_RUN) && rnd.in_advance && !accept);

    always_comb begin
        t_mix  = x_q ^ (x_q << 11);
        w_step = w_q ^ (w_q >> 19) ^ t_mix ^ (t_mix >> 8);
    end

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        z_d = z_q;
        w_d = w_q;
        if (accept) begin
            x_d = y_q;
            y_d = z_q;
            z_d = w_q;
            w_d = rnd.in_seed;
            // An all-zero xorshift state is a fixed point; break it.
            if (last_word && load_zero) begin
                x_d = 32'h1;
            end
        end else if (do_step) begin
            x_d = y_q;
            y_d = z_q;
            z_d = w_q;
            w_d = w_step;
        end
    end

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            x_q <= 32'd0;
            y_q <= 32'd0;
            z_q <= 32'd0;
            w_q <= 32'd0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            z_q <= z_d;
            w_q <= w_d;
        end
    end

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            fsm_q      <= S_UNSEEDED;
            word_cnt_q <= 2'd0;
            warm_cnt_q <= '0;
            ready_q    <= 1'b1;
            valid_q    <= 1'b0;
        end else begin
            case (fsm_q)
                S_UNSEEDED: begin
                    if (accept) begin
                        fsm_q      <= S_LOAD;
                        word_cnt_q <= 2'd1;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        if (word_cnt_q == 2'd3) begin
                            word_cnt_q <= 2'd0;
                            if (WARMUP_CYCLES == 0) begin
                                fsm_q   <= S_RUN;
                                valid_q <= 1'b1;
                            end else begin
                                fsm_q      <= S_WARMUP;
                                warm_cnt_q <= WCW'(WARMUP_CYCLES);
                                ready_q    <= 1'b0;
                            end
                        end else begin
                            word_cnt_q <= word_cnt_q + 2'd1;
                        end
                    end
                end
                S_WARMUP: begin
                    if (warm_cnt_q == WCW'(1)) begin
                        fsm_q      <= S_RUN;
                        warm_cnt_q <= '0;
                        ready_q    <= 1'b1;
                        valid_q    <= 1'b1;
                    end else begin
                        warm_cnt_q <= warm_cnt_q - WCW'(1);
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        fsm_q      <= S_LOAD;
                        word_cnt_q <= 2'd1;
                        valid_q    <= 1'b0;
                    end
                end
                default: begin
                    fsm_q   <= S_UNSEEDED;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign rnd.out_seed_ready   = ready_q;
    assign rnd.out_random_valid = valid_q;
    assign rnd.out_random       = valid_q ? NUM_RANDOM'({w_q, z_q, y_q, x_q}) : '0;
    assign out_fsm_state        = fsm_q;

endmodule

// File: tb/tb_masked_stage2_random_source.sv
// Directed bench for masked_stage2_random_source: three instances covering
// 14-bit/no warm-up, 128-bit/no warm-up and 14-bit/16-cycle warm-up.
module tb_masked_stage2_random_source;

    logic clk;
    logic rst;

    logic [31:0] ab_seed;
    logic        ab_sv;
    logic        ab_adv;
    logic [31:0] c_seed;
    logic        c_sv;
    logic        c_adv;

    logic [1:0] a_state, b_state, c_state;

    int checks   = 0;
    int failures = 0;

    masked_stage2_random_source_if #(.NUM_RANDOM(14))  if_a ();
    masked_stage2_random_source_if #(.NUM_RANDOM(128)) if_b ();
    masked_stage2_random_source_if #(.NUM_RANDOM(14))  if_c ();

    assign if_a.in_seed       = ab_seed;
    assign if_a.in_seed_valid = ab_sv;
    assign if_a.in_advance    = ab_adv;
    assign if_b.in_seed       = ab_seed;
    assign if_b.in_seed_valid = ab_sv;
    assign if_b.in_advance    = ab_adv;
    assign if_c.in_seed       = c_seed;
    assign if_c.in_seed_valid = c_sv;
    assign if_c.in_advance    = c_adv;

    masked_stage2_random_source #(.NUM_SHARES(2), .NUM_RANDOM(14), .WARMUP_CYCLES(0)) dut_a (
        .in_clock(clk), .in_reset(rst), .rnd(if_a), .out_fsm_state(a_state)
    );
    masked_stage2_random_source #(.NUM_SHARES(2), .NUM_RANDOM(128), .WARMUP_CYCLES(0)) dut_b (
        .in_clock(clk), .in_reset(rst), .rnd(if_b), .out_fsm_state(b_state)
    );
    masked_stage2_random_source #(.NUM_SHARES(2), .NUM_RANDOM(14), .WARMUP_CYCLES(16)) dut_c (
        .in_clock(clk), .in_reset(rst), .rnd(if_c), .out_fsm_state(c_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] xs_step(input logic [127:0] s);
        logic [31:0] x, y, z, w, t;
        x = s[31:0];
        y = s[63:32];
        z = s[95:64];
        w = s[127:96];
        t = x ^ (x << 11);
        return {w ^ (w >> 19) ^ t ^ (t >> 8), w, z, y};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_ab(input logic [31:0] word);
        ab_sv   = 1'b1;
        ab_seed = word;
        tick();
    endtask

    task automatic send_c(input logic [31:0] word);
        c_sv   = 1'b1;
        c_seed = word;
        tick();
    endtask

    initial begin : stim
        logic [127:0] model;
        rst = 1'b1;
        ab_seed = '0; ab_sv = 1'b0; ab_adv = 1'b0;
        c_seed  = '0; c_sv  = 1'b0; c_adv  = 1'b0;
        repeat (2) tick();

        check("rst_a_valid", 128'(if_a.out_random_valid), 128'd0);
        check("rst_a_random", 128'(if_a.out_random), 128'd0);
        check("rst_a_ready", 128'(if_a.out_seed_ready), 128'd1);
        check("rst_b_random", if_b.out_random, 128'd0);
        check("rst_c_ready", 128'(if_c.out_seed_ready), 128'd1);
        check("rst_a_state", 128'(a_state), 128'd0);
        rst = 1'b0;
        tick();

        // Seed 1,2,3,4 back-to-back into the no-warm-up instances.
        send_ab(32'd1);
        send_ab(32'd2);
        send_ab(32'd3);
        check("load3_a_valid", 128'(if_a.out_random_valid), 128'd0);
        send_ab(32'd4);
        ab_sv = 1'b0;
        check("seed_a_valid", 128'(if_a.out_random_valid), 128'd1);
        check("seed_a_random", 128'(if_a.out_random), 128'h1);
        check("seed_b_random", if_b.out_random, {32'h4, 32'h3, 32'h2, 32'h1});
        check("seed_a_state", 128'(a_state), 128'd3);

        ab_adv = 1'b1;
        tick();
        ab_adv = 1'b0;
        check("adv_a_random", 128'(if_a.out_random), 128'h2);
        check("adv_b_random", if_b.out_random, {32'h80D, 32'h4, 32'h3, 32'h2});

        tick();
        check("hold_a_random", 128'(if_a.out_random), 128'h2);
        check("hold_b_random", if_b.out_random, {32'h80D, 32'h4, 32'h3, 32'h2});

        // Reseed in RUN with in_advance asserted in the same cycle.
        ab_adv = 1'b1;
        send_ab(32'd1);
        ab_adv = 1'b0;
        check("reseed_a_valid", 128'(if_a.out_random_valid), 128'd0);
        check("reseed_a_random", 128'(if_a.out_random), 128'd0);
        check("reseed_a_state", 128'(a_state), 128'd1);
        check("reseed_a_ready", 128'(if_a.out_seed_ready), 128'd1);
        send_ab(32'd2);
        send_ab(32'd3);
        send_ab(32'd4);
        ab_sv = 1'b0;
        check("reseed_done_a_random", 128'(if_a.out_random), 128'h1);
        check("reseed_done_b_random", if_b.out_random, {32'h4, 32'h3, 32'h2, 32'h1});

        // All-zero seed: x forced to 1, then one step gives w = 0x809.
        repeat (4) send_ab(32'd0);
        ab_sv = 1'b0;
        check("zero_a_valid", 128'(if_a.out_random_valid), 128'd1);
        check("zero_a_random", 128'(if_a.out_random), 128'h1);
        check("zero_b_random", if_b.out_random, {32'h0, 32'h0, 32'h0, 32'h1});
        ab_adv = 1'b1;
        tick();
        ab_adv = 1'b0;
        check("zero_adv_a_random", 128'(if_a.out_random), 128'h0);
        check("zero_adv_b_random", if_b.out_random, {32'h809, 32'h0, 32'h0, 32'h0});

        // Asynchronous reset in RUN, between clock edges.
        #2;
        rst = 1'b1;
        #1;
        check("arst_run_a_valid", 128'(if_a.out_random_valid), 128'd0);
        check("arst_run_b_random", if_b.out_random, 128'd0);
        check("arst_run_a_state", 128'(a_state), 128'd0);
        tick();
        rst = 1'b0;
        tick();

        // Reset after two seed words; a full reload is required afterwards.
        send_ab(32'd1);
        send_ab(32'd2);
        ab_sv = 1'b0;
        check("part_a_state", 128'(a_state), 128'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_load_a_valid", 128'(if_a.out_random_valid), 128'd0);
        check("arst_load_a_random", 128'(if_a.out_random), 128'd0);
        check("arst_load_a_ready", 128'(if_a.out_seed_ready), 128'd1);
        check("arst_load_a_state", 128'(a_state), 128'd0);
        tick();
        rst = 1'b0;
        tick();
        send_ab(32'd1);
        send_ab(32'd2);
        send_ab(32'd3);
        check("reload3_a_valid", 128'(if_a.out_random_valid), 128'd0);
        send_ab(32'd4);
        ab_sv = 1'b0;
        check("reload_a_valid", 128'(if_a.out_random_valid), 128'd1);
        check("reload_a_random", 128'(if_a.out_random), 128'h1);

        // Warm-up instance: 16 discarded steps, seeds and advance ignored meanwhile.
        send_c(32'd1);
        send_c(32'd2);
        send_c(32'd3);
        send_c(32'd4);
        check("warm0_c_valid", 128'(if_c.out_random_valid), 128'd0);
        check("warm0_c_ready", 128'(if_c.out_seed_ready), 128'd0);
        c_seed = 32'hFFFF_FFFF;
        c_adv  = 1'b1;
        model  = {32'h4, 32'h3, 32'h2, 32'h1};
        for (int i = 1; i <= 16; i++) begin
            tick();
            model = xs_step(model);
            if (i < 16) begin
                check($sformatf("warm%0d_c_valid", i), 128'(if_c.out_random_valid), 128'd0);
                check($sformatf("warm%0d_c_ready", i), 128'(if_c.out_seed_ready), 128'd0);
            end else begin
                check("warm16_c_valid", 128'(if_c.out_random_valid), 128'd1);
                check("warm16_c_ready", 128'(if_c.out_seed_ready), 128'd1);
            end
        end
        c_sv  = 1'b0;
        c_adv = 1'b0;
        check("warm_c_random", 128'(if_c.out_random), 128'(model[13:0]));
        tick();
        check("warm_hold_c_random", 128'(if_c.out_random), 128'(model[13:0]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
